vga_timing_decoder: RTL and testbench

- Sink-side counterpart of the VGA timing generator: consumes hsync/vsync/blank at pixel clock, recovers active-pixel x/y coordinates, measures line/frame geometry, declares lock.
- Sits on the pixel-clock domain downstream of the display path; feeds capture, overlay and self-check logic for the Pong video pipe.

---
 rtl/vga_timing_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// VGA timing decoder: recovers active-pixel coordinates and line/frame geometry from hsync, vsync
// and blank, and declares lock. Define VGA_DEC_EXPECT_CHECK_EN to compare geometry against EXP_*.
module vga_timing_decoder #(
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter int unsigned TIMEOUT      = 2047,
  parameter int unsigned EXP_H_TOTAL  = 800,
  parameter int unsigned EXP_V_TOTAL  = 525,
  parameter int unsigned EXP_H_ACTIVE = 640,
  parameter int unsigned EXP_V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_period,
  output logic [10:0] v_lines,
  output logic [10:0] h_active,
  output logic [10:0] v_active,
  output logic        locked,
  output logic        fmt_ok
);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  localparam logic [3:0]  LockFrames = 4'(LOCK_FRAMES);
  localparam logic [10:0] Timeout    = 11'(TIMEOUT);

  function automatic logic [10:0] inc11(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] inc10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  logic        hs_q, vs_q, bl_q;
  logic [10:0] hcnt_q, act_cnt_q, line_cnt_q, act_lines_q;
  logic [10:0] first_period_q, prev_h_q, prev_v_q;
  logic        have_first_q, h_var_q, ref_valid_q;
  logic [3:0]  match_cnt_q;
  state_e      state_q;

  logic        line_ev, frame_ev, bl_rise, bl_fall, timeout;
  logic [10:0] period, h_period_new, lines_new, act_lines_new, h_active_new;
  logic        h_var_new, frame_match;
  state_e      state_d;
  logic [3:0]  match_cnt_d;
  logic        ref_valid_d;

  // The line event is folded in before the frame event so a coincident line counts toward the
  // frame that is ending.
  always_comb begin
    line_ev       = hs_q & ~hsync;
    frame_ev      = vs_q & ~vsync;
    bl_rise       = ~bl_q & blank;
    bl_fall       = bl_q & ~blank;
    timeout       = hcnt_q >= Timeout;
    period        = inc11(hcnt_q);
    h_period_new  = line_ev ? period : h_period;
    lines_new     = line_ev ? inc11(line_cnt_q) : line_cnt_q;
    act_lines_new = bl_fall ? inc11(act_lines_q) : act_lines_q;
    h_active_new  = bl_fall ? act_cnt_q : h_active;
    h_var_new     = h_var_q | (line_ev & have_first_q & (period != first_period_q));
    frame_match   = ~h_var_new & (h_period_new == prev_h_q) & (lines_new == prev_v_q);
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    ref_valid_d = ref_valid_q;
    if (timeout) begin
      state_d     = StSearch;
      match_cnt_d = 4'd0;
      ref_valid_d = 1'b0;
    end else if (frame_ev) begin
      unique case (state_q)
        StSearch: begin
          state_d     = StTrack;
          match_cnt_d = 4'd0;
          ref_valid_d = 1'b0;
        end
        StTrack: begin
          // First complete frame after search only establishes the reference.
          if (!ref_valid_q) begin
            ref_valid_d = 1'b1;
            match_cnt_d = h_var_new ? 4'd0 : 4'd1;
          end else if (frame_match) begin
            match_cnt_d = match_cnt_q + 4'd1;
          end else begin
            match_cnt_d = 4'd0;
          end
          if (match_cnt_d >= LockFrames) begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (!frame_match) begin
            state_d     = StTrack;
            match_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d     = StSearch;
          match_cnt_d = 4'd0;
          ref_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      bl_q           <= 1'b0;
      x              <= '0;
      y              <= '0;
      pixel_valid    <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      h_period       <= '0;
      v_lines        <= '0;
      h_active       <= '0;
      v_active       <= '0;
      locked         <= 1'b0;
      hcnt_q         <= '0;
      act_cnt_q      <= '0;
      line_cnt_q     <= '0;
      act_lines_q    <= '0;
      first_period_q <= '0;
      prev_h_q       <= '0;
      prev_v_q       <= '0;
      have_first_q   <= 1'b0;
      h_var_q        <= 1'b0;
      ref_valid_q    <= 1'b0;
      match_cnt_q    <= '0;
      state_q        <= StSearch;
    end else begin
      hs_q        <= hsync;
      vs_q        <= vsync;
      bl_q        <= blank;
      line_start  <= line_ev;
      frame_start <= frame_ev;
      pixel_valid <= blank;
      locked      <= (state_q == StLocked);
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      ref_valid_q <= ref_valid_d;

      if (bl_rise) begin
        x <= '0;
      end else if (blank) begin
        x <= inc10(x);
      end

      if (frame_ev) begin
        y <= '0;
      end else if (bl_fall) begin
        y <= inc10(y);
      end

      hcnt_q <= line_ev ? 11'd0 : inc11(hcnt_q);

      if (bl_rise) begin
        act_cnt_q <= 11'd1;
      end else if (blank) begin
        act_cnt_q <= inc11(act_cnt_q);
      end

      h_period <= h_period_new;
      h_active <= h_active_new;

      if (frame_ev) begin
        line_cnt_q   <= '0;
        act_lines_q  <= '0;
        h_var_q      <= 1'b0;
        have_first_q <= 1'b0;
        // The frame that ends at the search exit is partial and is not measured.
        if (state_q != StSearch) begin
          v_lines  <= lines_new;
          v_active <= act_lines_new;
          prev_h_q <= h_period_new;
          prev_v_q <= lines_new;
        end
      end else begin
        line_cnt_q  <= lines_new;
        act_lines_q <= act_lines_new;
        h_var_q     <= h_var_new;
        if (line_ev && !have_first_q) begin
          first_period_q <= period;
          have_first_q   <= 1'b1;
        end
      end

      if (timeout) begin
        h_period     <= '0;
        v_lines      <= '0;
        prev_h_q     <= '0;
        prev_v_q     <= '0;
        line_cnt_q   <= '0;
        act_lines_q  <= '0;
        h_var_q      <= 1'b0;
        have_first_q <= 1'b0;
      end
    end
  end

`ifdef VGA_DEC_EXPECT_CHECK_EN
  logic fmt_match;
  assign fmt_match = (h_period_new == 11'(EXP_H_TOTAL)) & (lines_new == 11'(EXP_V_TOTAL)) &
                     (h_active_new == 11'(EXP_H_ACTIVE)) & (act_lines_new == 11'(EXP_V_ACTIVE));

  // Gated by the same state that drives locked, so fmt_ok is never high while locked is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      fmt_ok <= 1'b0;
    end else if (state_q != StLocked) begin
      fmt_ok <= 1'b0;
    end else if (frame_ev) begin
      fmt_ok <= fmt_match;
    end
  end
`else
  assign fmt_ok = 1'b0;

  logic unused_exp_params;
  assign unused_exp_params = ^{11'(EXP_H_TOTAL), 11'(EXP_V_TOTAL), 11'(EXP_H_ACTIVE),
                               11'(EXP_V_ACTIVE)};
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a scaled-down VGA raster so the run stays short.
module tb_vga_timing_decoder;

  localparam int H_TOT       = 100;
  localparam int H_SYNC      = 10;
  localparam int H_ACT_START = 20;
  localparam int H_ACT       = 64;
  localparam int V_TOT       = 20;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_START = 5;
  localparam int V_ACT       = 12;
`ifdef VGA_DEC_EXPECT_CHECK_EN
  localparam logic FmtOn = 1'b1;
`else
  localparam logic FmtOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, hsync, vsync, blank;
  logic [9:0]  x, y;
  logic        pixel_valid, line_start, frame_start, locked, fmt_ok;
  logic [10:0] h_period, v_lines, h_active, v_active;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic locked_prev = 1'b0;
  int   fs_drv_q[$];
  int   lock_rise_q[$];
  int   lock_fall_q[$];

  vga_timing_decoder #(
    .LOCK_FRAMES (2),
    .TIMEOUT     (2047),
    .EXP_H_TOTAL (H_TOT),
    .EXP_V_TOTAL (V_TOT),
    .EXP_H_ACTIVE(H_ACT),
    .EXP_V_ACTIVE(V_ACT)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .x          (x),
    .y          (y),
    .pixel_valid(pixel_valid),
    .line_start (line_start),
    .frame_start(frame_start),
    .h_period   (h_period),
    .v_lines    (v_lines),
    .h_active   (h_active),
    .v_active   (v_active),
    .locked     (locked),
    .fmt_ok     (fmt_ok)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One pixel clock: drive inputs, then sample just after the active edge.
  task automatic tick(input logic hs, input logic vs, input logic bl);
    hsync = hs;
    vsync = vs;
    blank = bl;
    @(posedge clk);
    #1;
    cyc++;
    if (locked && !locked_prev) lock_rise_q.push_back(cyc);
    if (!locked && locked_prev) lock_fall_q.push_back(cyc);
    locked_prev = locked;
  endtask

  task automatic run_frame(input int htot, input int short_line, input bit probe);
    int last_l;
    last_l = V_ACT_START + V_ACT - 1;
    for (int l = 0; l < V_TOT; l++) begin
      int len;
      len = (l == short_line) ? htot - 1 : htot;
      for (int c = 0; c < len; c++) begin
        tick(c >= H_SYNC, l >= V_SYNC,
             (l >= V_ACT_START) && (l < V_ACT_START + V_ACT) &&
             (c >= H_ACT_START) && (c < H_ACT_START + H_ACT));
        if (l == 0 && c == 0) fs_drv_q.push_back(cyc);
        if (probe) begin
          if (l == 0 && c == 0) check_eq("sync_both", {line_start, frame_start}, 2'b11);
          if (l == 0 && c == 1) check_eq("sync_pulse_end", {line_start, frame_start}, 2'b00);
          if (l == 1 && c == 0) check_eq("line_only", {line_start, frame_start}, 2'b10);
          if (l == V_ACT_START && c == H_ACT_START) begin
            check_eq("first_x", x, 0);
            check_eq("first_y", y, 0);
            check_eq("first_pv", pixel_valid, 1);
          end
          if (l == V_ACT_START && c == H_ACT_START + 1) check_eq("second_x", x, 1);
          if (l == V_ACT_START + 1 && c == H_ACT_START) check_eq("second_line_y", y, 1);
          if (l == last_l && c == H_ACT_START + H_ACT - 1) begin
            check_eq("last_x", x, H_ACT - 1);
            check_eq("last_y", y, V_ACT - 1);
            check_eq("last_pv", pixel_valid, 1);
          end
          if (l == last_l && c == H_ACT_START + H_ACT + 4) begin
            check_eq("hold_x", x, H_ACT - 1);
            check_eq("hold_pv", pixel_valid, 0);
          end
        end
      end
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_pv", pixel_valid, 0);
    check_eq("rst_pulses", {line_start, frame_start}, 2'b00);
    check_eq("rst_h_period", h_period, 0);
    check_eq("rst_v_lines", v_lines, 0);
    check_eq("rst_h_active", h_active, 0);
    check_eq("rst_v_active", v_active, 0);
    check_eq("rst_lock_fmt", {locked, fmt_ok}, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);

    // Clean stream: lock one clock after the third frame start.
    run_frame(H_TOT, -1, 1'b1);
    run_frame(H_TOT, -1, 1'b0);
    run_frame(H_TOT, -1, 1'b0);
    check_eq("locked_a", locked, 1);
    check_eq("lock_rise_a", q_at(lock_rise_q, 0), q_at(fs_drv_q, 2) + 1);
    check_eq("h_period_a", h_period, H_TOT);
    check_eq("v_lines_a", v_lines, V_TOT);
    check_eq("h_active_a", h_active, H_ACT);
    check_eq("v_active_a", v_active, V_ACT);

    // One short line: lock drops after the next frame start, then relocks after 2 clean frames.
    run_frame(H_TOT, 8, 1'b0);
    check_eq("locked_short_frame", locked, 1);
    check_eq("fmt_ok_clean", fmt_ok, FmtOn);
    run_frame(H_TOT, -1, 1'b0);
    check_eq("lock_fall_b", q_at(lock_fall_q, 0), q_at(fs_drv_q, 4) + 1);
    run_frame(H_TOT, -1, 1'b0);
    check_eq("unlocked_b", locked, 0);
    run_frame(H_TOT, -1, 1'b0);
    check_eq("relocked_b", locked, 1);
    check_eq("lock_rise_b", q_at(lock_rise_q, 1), q_at(fs_drv_q, 6) + 1);

    // Loss of signal.
    for (int i = 0; i < 2100; i++) tick(1'b1, 1'b1, 1'b0);
    check_eq("timeout_locked", locked, 0);
    check_eq("timeout_h_period", h_period, 0);
    check_eq("timeout_v_lines", v_lines, 0);
    check_eq("timeout_fall_count", lock_fall_q.size(), 2);

    // Off-format stream still locks but does not match the expected geometry.
    for (int f = 0; f < 4; f++) run_frame(H_TOT + 1, -1, 1'b0);
    check_eq("locked_d", locked, 1);
    check_eq("h_period_d", h_period, H_TOT + 1);
    check_eq("v_lines_d", v_lines, V_TOT);
    check_eq("fmt_ok_off", fmt_ok, 0);

    // Reset mid-stream.
    reset = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check_eq("midrst_locked", locked, 0);
    check_eq("midrst_h_period", h_period, 0);
    check_eq("midrst_pv", pixel_valid, 0);
    reset = 1'b0;

    // Long active run: x saturates, active counter keeps going.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 1'b1);
    check_eq("sat_x", x, 1023);
    tick(1'b1, 1'b1, 1'b0);
    check_eq("sat_h_active", h_active, 1100);
    check_eq("sat_x_hold", x, 1023);
    check_eq("sat_y", y, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
